// File: rtl/rom_rr_arbiter.sv
// Round-robin arbiter sharing one registered-output ROM among NREQ requesters.
// Grants are combinational; a LAT-deep one-hot tag pipeline routes each returned word.
module rom_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int AW   = 6,
  parameter int DW   = 20,
  parameter int LAT  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] addr_in,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    rvalid,
  output logic [DW-1:0]      rdata,
  output logic               rom_en,
  output logic [AW-1:0]      rom_addr,
  input  logic [DW-1:0]      rom_data
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int SW = IW + 1;

  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   win;
  logic [IW-1:0]   idx;
  logic [SW-1:0]   sum;
  logic            found;
  logic [NREQ-1:0] req_eff;
  logic [AW-1:0]   addr_arr [NREQ];
  logic [NREQ-1:0] tag_q [LAT];

  // Requests are masked while reset is held so no grant or ROM read leaks out.
  assign req_eff = rst_n ? req : '0;

  for (genvar i = 0; i < NREQ; i++) begin : g_addr
    assign addr_arr[i] = addr_in[i*AW +: AW];
  end

  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    sum   = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, ptr_q} + SW'(k);
      if (sum >= SW'(NREQ)) sum = sum - SW'(NREQ);
      idx = sum[IW-1:0];
      if (!found && req_eff[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    gnt      = '0;
    rom_en   = 1'b0;
    rom_addr = '0;
    ptr_d    = ptr_q;
    if (found) begin
      gnt[win] = 1'b1;
      rom_en   = 1'b1;
      rom_addr = addr_arr[win];
      if (win == IW'(NREQ - 1)) ptr_d = '0;
      else                      ptr_d = win + 1'b1;
    end
  end

  // Stage 0 captures the grant vector; the last stage is the rvalid strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      for (int k = 0; k < LAT; k++) tag_q[k] <= '0;
    end else begin
      ptr_q    <= ptr_d;
      tag_q[0] <= gnt;
      for (int k = 1; k < LAT; k++) tag_q[k] <= tag_q[k-1];
    end
  end

  assign rvalid = tag_q[LAT-1];
  assign rdata  = rom_data;

  a_gnt_onehot0:    assert property (@(posedge clk) $onehot0(gnt));
  a_rvalid_onehot0: assert property (@(posedge clk) $onehot0(rvalid));
  a_rom_en_gnt:     assert property (@(posedge clk) rom_en == (|gnt));

endmodule
